// File: rtl/seg7_pkg.sv
// Shared definitions for the memory-mapped 7-segment scan controller.
// Contents: bus width, register-window layout, CTRL field positions,
// the packed CTRL register type, the scan state type and the segment
// patterns for decimal digits 0..9 ({g,f,e,d,c,b,a}, active-high).
// Optional build macro: SEG7_HEX_DECODE_EN (enables CTRL.HEX storage and
// the hex nibble decoder).
package seg7_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] SEG7_BASE_ADDR = 32'h0000_0400;
  localparam logic [XLEN-1:0] SEG7_CTRL_OFS  = 32'h0000_0020;
  localparam logic [XLEN-1:0] SEG7_WIN_SIZE  = 32'h0000_0040;

  localparam int unsigned CTRL_EN_BIT   = 0;
  localparam int unsigned CTRL_DUTY_LSB = 1;
  localparam int unsigned CTRL_DUTY_MSB = 4;
  localparam int unsigned CTRL_HEX_BIT  = 8;

  typedef struct packed {
    logic       hex;
    logic [3:0] duty;
    logic       en;
  } seg7_ctrl_t;

  localparam seg7_ctrl_t SEG7_CTRL_RST = '{hex: 1'b0, duty: 4'hF, en: 1'b1};

  typedef enum logic {
    SCAN_IDLE,
    SCAN_RUN
  } seg7_state_t;

  localparam logic [6:0] SEG7_PAT_0 = 7'h3F;
  localparam logic [6:0] SEG7_PAT_1 = 7'h06;
  localparam logic [6:0] SEG7_PAT_2 = 7'h5B;
  localparam logic [6:0] SEG7_PAT_3 = 7'h4F;
  localparam logic [6:0] SEG7_PAT_4 = 7'h66;
  localparam logic [6:0] SEG7_PAT_5 = 7'h6D;
  localparam logic [6:0] SEG7_PAT_6 = 7'h7D;
  localparam logic [6:0] SEG7_PAT_7 = 7'h07;
  localparam logic [6:0] SEG7_PAT_8 = 7'h7F;
  localparam logic [6:0] SEG7_PAT_9 = 7'h6F;

  // Bus image of the CTRL register.
  function automatic logic [XLEN-1:0] ctrl_to_word(input seg7_ctrl_t c);
    logic [XLEN-1:0] w;
    w = '0;
    w[CTRL_EN_BIT]                 = c.en;
    w[CTRL_DUTY_MSB:CTRL_DUTY_LSB] = c.duty;
    w[CTRL_HEX_BIT]                = c.hex;
    return w;
  endfunction

endpackage

// File: rtl/seg7_scan_ctrl_hex_decoder.sv
// seg7_hex_decoder: combinational 4-bit hex nibble to 7-segment decoder.
// Ports: nibble (4-bit value), seg (7-bit {g,f,e,d,c,b,a}, active-high).
// Only compiled when SEG7_HEX_DECODE_EN is defined.
`ifdef SEG7_HEX_DECODE_EN
module seg7_hex_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = '0;
    unique case (nibble)
      4'h0: seg = SEG7_PAT_0;
      4'h1: seg = SEG7_PAT_1;
      4'h2: seg = SEG7_PAT_2;
      4'h3: seg = SEG7_PAT_3;
      4'h4: seg = SEG7_PAT_4;
      4'h5: seg = SEG7_PAT_5;
      4'h6: seg = SEG7_PAT_6;
      4'h7: seg = SEG7_PAT_7;
      4'h8: seg = SEG7_PAT_8;
      4'h9: seg = SEG7_PAT_9;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      4'hF: seg = 7'h71;
      default: seg = '0;
    endcase
  end

endmodule
`endif

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: memory-mapped multiplexing controller for a
// NUM_DIGITS-digit 7-segment display with PWM brightness.
// Register window at BASE_ADDR (addr[1:0] ignored):
//   +4k  DIGIT[k] bits[6:0]     +0x20 CTRL: bit0 EN, bits[4:1] DUTY, bit8 HEX
// Ports:
//   clk_i, rst_i (async, active-high)
//   wr_en_i/wr_addr_i/wr_data_i  store path from the core
//   rd_en_i/rd_addr_i            load request; rd_data_o/rd_valid_o one cycle later
//   seg_o {g,f,e,d,c,b,a}, an_o one-hot digit enable, frame_o wrap pulse
// Optional build macro: SEG7_HEX_DECODE_EN (CTRL.HEX selects hex decoding
// of DIGIT[k][3:0]; without it HEX is not stored and reads as 0).
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int unsigned     NUM_DIGITS     = 4,
  parameter int unsigned     SCAN_DIV       = 50000,
  parameter logic [XLEN-1:0] BASE_ADDR      = SEG7_BASE_ADDR,
  parameter bit              SEG_ACTIVE_LOW = 1'b0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wr_en_i,
  input  logic [XLEN-1:0]       wr_addr_i,
  input  logic [XLEN-1:0]       wr_data_i,
  input  logic                  rd_en_i,
  input  logic [XLEN-1:0]       rd_addr_i,
  output logic [XLEN-1:0]       rd_data_o,
  output logic                  rd_valid_o,
  output logic [6:0]            seg_o,
  output logic [NUM_DIGITS-1:0] an_o,
  output logic                  frame_o
);

  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned PRE_W = $clog2(SCAN_DIV);

  localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [PRE_W-1:0]      LAST_PRE  = PRE_W'(SCAN_DIV - 1);
  localparam logic [3:0]            CTRL_WORD = SEG7_CTRL_OFS[5:2];
  localparam logic [6:0]            SEG_OFF   = SEG_ACTIVE_LOW ? '1 : '0;
  localparam logic [NUM_DIGITS-1:0] AN_OFF    = SEG_ACTIVE_LOW ? '1 : '0;

  logic [6:0]      digit [NUM_DIGITS];
  seg7_ctrl_t      ctrl;

  logic [XLEN-1:0] wr_ofs, rd_ofs;
  logic            wr_win, rd_win;
  logic [3:0]      wr_word, rd_word;
  logic [XLEN-1:0] rd_val;

  seg7_state_t     state;
  logic [PRE_W-1:0] presc;
  logic [IDX_W-1:0] idx, nxt_idx;
  logic [6:0]      shadow;
  logic [6:0]      pattern;
  logic [3:0]      pwm;
  logic [NUM_DIGITS-1:0] an_sel;

  // Address decode: window-relative word index.
  assign wr_ofs  = wr_addr_i - BASE_ADDR;
  assign rd_ofs  = rd_addr_i - BASE_ADDR;
  assign wr_win  = (wr_ofs < SEG7_WIN_SIZE);
  assign rd_win  = (rd_ofs < SEG7_WIN_SIZE);
  assign wr_word = wr_ofs[5:2];
  assign rd_word = rd_ofs[5:2];

  logic unused_bits;
  assign unused_bits = ^{wr_ofs[1:0], rd_ofs[1:0], wr_data_i[XLEN-1:8],
                         wr_data_i[7:5]};

  // Register file.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned k = 0; k < NUM_DIGITS; k++) digit[k] <= '0;
      ctrl <= SEG7_CTRL_RST;
    end else if (wr_en_i && wr_win) begin
      for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
        if (wr_word == 4'(k)) digit[k] <= wr_data_i[6:0];
      end
      if (wr_word == CTRL_WORD) begin
        ctrl.en   <= wr_data_i[CTRL_EN_BIT];
        ctrl.duty <= wr_data_i[CTRL_DUTY_MSB:CTRL_DUTY_LSB];
`ifdef SEG7_HEX_DECODE_EN
        ctrl.hex  <= wr_data_i[CTRL_HEX_BIT];
`else
        ctrl.hex  <= 1'b0;
`endif
      end
    end
  end

  // Read mux uses pre-edge register values, so a same-cycle write is not visible.
  always_comb begin
    rd_val = '0;
    if (rd_win) begin
      for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
        if (rd_word == 4'(k)) rd_val = XLEN'(digit[k]);
      end
      if (rd_word == CTRL_WORD) rd_val = ctrl_to_word(ctrl);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_data_o  <= '0;
      rd_valid_o <= 1'b0;
    end else begin
      rd_data_o  <= (rd_en_i && rd_win) ? rd_val : '0;
      rd_valid_o <= rd_en_i && rd_win;
    end
  end

  // Segment pattern source for the active slot.
`ifdef SEG7_HEX_DECODE_EN
  logic [6:0] hex_seg;

  seg7_hex_decoder u_hex_decoder (
    .nibble (shadow[3:0]),
    .seg    (hex_seg)
  );

  assign pattern = ctrl.hex ? hex_seg : shadow;
`else
  assign pattern = shadow;
`endif

  assign nxt_idx = (idx == LAST_IDX) ? '0 : idx + 1'b1;

  always_comb begin
    an_sel = '0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      if (idx == IDX_W'(k)) an_sel[k] = 1'b1;
    end
  end

  // Scan FSM with registered pin outputs; the output flops reflect the
  // index/shadow of the previous cycle. The shadow is loaded on the edge
  // that starts a slot, from pre-edge DIGIT contents, so a write landing on
  // that same edge only shows up in the digit's following slot.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= SCAN_IDLE;
      presc   <= '0;
      idx     <= '0;
      shadow  <= '0;
      pwm     <= '0;
      frame_o <= 1'b0;
      seg_o   <= SEG_OFF;
      an_o    <= AN_OFF;
    end else begin
      pwm     <= pwm + 1'b1;
      frame_o <= 1'b0;
      seg_o   <= SEG_OFF;
      an_o    <= AN_OFF;
      unique case (state)
        SCAN_IDLE: begin
          if (ctrl.en) begin
            state  <= SCAN_RUN;
            presc  <= '0;
            idx    <= '0;
            shadow <= digit[0];
          end
        end
        SCAN_RUN: begin
          if (!ctrl.en) begin
            state <= SCAN_IDLE;
            presc <= '0;
            idx   <= '0;
          end else begin
            an_o <= an_sel ^ AN_OFF;
            if (pwm <= ctrl.duty) seg_o <= pattern ^ SEG_OFF;
            if (presc == LAST_PRE) begin
              presc   <= '0;
              idx     <= nxt_idx;
              shadow  <= digit[nxt_idx];
              frame_o <= (idx == LAST_IDX);
            end else begin
              presc <= presc + 1'b1;
            end
          end
        end
        default: state <= SCAN_IDLE;
      endcase
    end
  end

endmodule
